// File: rtl/spi_slave_regfile.sv
// SPI slave register file: pclk-oversampled SPI decoding 8-bit address + 8-bit data frames, LSB first.
// Optional miso readback of read frames is enabled by defining SPI_SLV_READBACK_EN.
module spi_slave_regfile #(
  parameter int unsigned AW          = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          pclk_i,
  input  logic          prst_i,
  input  logic          sclk_i,
  input  logic          cs_n_i,
  input  logic          mosi_i,
  output logic          miso_o,
  output logic          wr_done_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  output logic          abort_o
);
  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned CW    = 3;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_q;
  logic [CW-1:0]          r_cnt;
  logic [6:0]             r_shift;
  logic [AW-1:0]          r_addr;
  logic                   r_is_wr;
  logic                   r_wr_pend;
  logic [7:0]             r_mem [DEPTH];

  logic       w_sclk, w_cs_n, w_mosi, w_rise, w_last, w_leave;
  logic [7:0] w_byte;
  logic       w_shift_en, w_cnt_clr, w_addr_done, w_commit, w_abort;

  assign w_sclk  = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n  = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise  = ~w_cs_n & w_sclk & ~r_sclk_q;
  assign w_last  = w_rise & (r_cnt == CW'(7));
  assign w_leave = (r_state != S_IDLE) & w_cs_n;
  assign w_byte  = {w_mosi, r_shift};

  // Input synchronisers; idle values on reset so no spurious edges appear
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_q    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      r_sclk_q    <= w_sclk;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // CS release is checked first so it wins over a coincident 8th bit
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_cs_n) w_state_nxt = S_ADDR;
      S_ADDR:  if (w_cs_n) w_state_nxt = S_IDLE; else if (w_last) w_state_nxt = S_DATA;
      S_DATA:  if (w_cs_n) w_state_nxt = S_IDLE; else if (w_last) w_state_nxt = S_ADDR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_shift_en  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_addr_done = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    if (r_state == S_IDLE || w_leave) w_cnt_clr = 1'b1;
    if (w_leave) begin
      w_abort = (r_cnt != CW'(0)) || (r_state == S_DATA);
    end else if (r_state != S_IDLE) begin
      w_shift_en  = w_rise;
      w_addr_done = (r_state == S_ADDR) & w_last;
      w_commit    = (r_state == S_DATA) & w_last & r_is_wr;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_is_wr   <= 1'b0;
      r_wr_pend <= 1'b0;
      wr_done_o <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= 8'h00;
      abort_o   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[AW'(i)] <= 8'h00;
    end else begin
      r_wr_pend <= w_commit;
      wr_done_o <= r_wr_pend;
      abort_o   <= w_abort;
      if (w_cnt_clr)       r_cnt <= '0;
      else if (w_shift_en) r_cnt <= r_cnt + CW'(1);
      if (w_shift_en) r_shift <= w_byte[7:1];
      if (w_addr_done) begin
        r_addr  <= w_byte[AW-1:0];
        r_is_wr <= w_byte[7];
      end
      if (w_commit) begin
        r_mem[r_addr] <= w_byte;
        wr_addr_o     <= r_addr;
        wr_data_o     <= w_byte;
      end
    end
  end

`ifdef SPI_SLV_READBACK_EN
  logic [6:0] r_sout;
  logic       r_miso;
  logic       w_fall;
  logic [7:0] w_mem_rd;

  assign w_fall   = ~w_cs_n & ~w_sclk & r_sclk_q;
  assign w_mem_rd = r_mem[w_byte[AW-1:0]];

  // Bit 0 goes out at address decode; the trailing fall of the address byte (count 0) is skipped
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      r_sout <= '0;
      r_miso <= 1'b1;
    end else if (w_addr_done && !w_byte[7]) begin
      r_sout <= w_mem_rd[7:1];
      r_miso <= w_mem_rd[0];
    end else if (w_state_nxt == S_DATA && !r_is_wr) begin
      if (w_fall && r_cnt != CW'(0)) begin
        r_sout <= {1'b0, r_sout[6:1]};
        r_miso <= r_sout[0];
      end
    end else begin
      r_miso <= 1'b1;
    end
  end

  assign miso_o = r_miso;
`else
  assign miso_o = 1'b1;
`endif

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: directed scenarios plus randomized frames vs a register-file model.
`timescale 1ns/1ps
module tb_spi_slave_regfile;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          pclk = 1'b0;
  logic          prst_i, sclk_i, cs_n_i, mosi_i;
  logic          miso_o, wr_done_o, abort_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;

  spi_slave_regfile #(.AW(AW), .SYNC_STAGES(2)) dut (
    .pclk_i(pclk), .prst_i(prst_i), .sclk_i(sclk_i), .cs_n_i(cs_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .wr_done_o(wr_done_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .abort_o(abort_o)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic [7:0]    ref_mem [DEPTH];
  logic [AW-1:0] last_addr;
  logic [7:0]    last_data;

  // Pulses last one pclk, so one sample per cycle counts each pulse once
  always @(negedge pclk) begin
    if (wr_done_o === 1'b1) done_cnt++;
    if (abort_o === 1'b1) abort_cnt++;
  end

  task automatic half_bit();
    repeat (4) @(negedge pclk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 0; i < n; i++) begin
      mosi_i = b[i];
      half_bit();
      rx[i] = miso_o;
      sclk_i = 1'b1;
      half_bit();
      sclk_i = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n_i = 1'b0;
    half_bit();
  endtask

  task automatic cs_end();
    half_bit();
    cs_n_i = 1'b1;
    repeat (8) @(negedge pclk);
  endtask

  function automatic void model_frame(input logic [7:0] a, input logic [7:0] d);
    if (a[7]) begin
      ref_mem[a[AW-1:0]] = d;
      last_addr = a[AW-1:0];
      last_data = d;
    end
  endfunction

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, output logic [7:0] rx);
    logic [7:0] dummy;
    spi_bits(a, 8, dummy);
    spi_bits(d, 8, rx);
    model_frame(a, d);
  endtask

  function automatic void clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    last_addr = '0;
    last_data = 8'h00;
  endfunction

  task automatic test_reset();
    prst_i = 1'b1;
    repeat (3) @(negedge pclk);
    prst_i = 1'b0;
    clear_model();
    @(negedge pclk);
    n_cmp++; if (miso_o !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b want 1", miso_o); end
    n_cmp++; if (wr_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_done: got %b want 0", wr_done_o); end
    n_cmp++; if (wr_addr_o !== 4'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr_o); end
    n_cmp++; if (wr_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data_o); end
    n_cmp++; if (abort_o !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", abort_o); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (dut.r_mem[i] !== 8'h00) begin n_fail++; $display("FAIL reset_mem[%0d]: got %h want 00", i, dut.r_mem[i]); end
    end
  endtask

  task automatic test_write();
    int d0 = done_cnt;
    int a0 = abort_cnt;
    logic [7:0] rx;
    cs_begin();
    send_frame(8'hD3, 8'h46, rx);
    cs_end();
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL write_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (abort_cnt != a0) begin n_fail++; $display("FAIL write_no_abort: got %0d want 0", abort_cnt - a0); end
    n_cmp++; if (wr_addr_o !== 4'h3) begin n_fail++; $display("FAIL write_addr: got %h want 3", wr_addr_o); end
    n_cmp++; if (wr_data_o !== 8'h46) begin n_fail++; $display("FAIL write_data: got %h want 46", wr_data_o); end
    n_cmp++; if (dut.r_mem[3] !== 8'h46) begin n_fail++; $display("FAIL write_mem3: got %h want 46", dut.r_mem[3]); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    logic [7:0] rx;
    cs_begin();
    for (int k = 0; k < 8; k++) send_frame(8'(8'hD3 + k), 8'(8'h46 + k), rx);
    cs_end();
    n_cmp++; if (done_cnt - d0 != 8) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 8", done_cnt - d0); end
    n_cmp++; if (wr_addr_o !== 4'hA) begin n_fail++; $display("FAIL b2b_last_addr: got %h want a", wr_addr_o); end
    n_cmp++; if (wr_data_o !== 8'h4D) begin n_fail++; $display("FAIL b2b_last_data: got %h want 4d", wr_data_o); end
    for (int i = 3; i <= 10; i++) begin
      n_cmp++;
      if (dut.r_mem[i] !== 8'(8'h43 + i)) begin
        n_fail++; $display("FAIL b2b_mem[%0d]: got %h want %h", i, dut.r_mem[i], 8'(8'h43 + i));
      end
    end
  endtask

  task automatic test_abort();
    int d0 = done_cnt;
    int a0 = abort_cnt;
    logic [7:0] rx;
    cs_begin();
    spi_bits(8'hD5, 8, rx);
    spi_bits(8'h77, 5, rx);
    cs_end();
    n_cmp++; if (abort_cnt - a0 != 1) begin n_fail++; $display("FAIL abort_pulses: got %0d want 1", abort_cnt - a0); end
    n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (dut.r_mem[5] !== ref_mem[5]) begin n_fail++; $display("FAIL abort_mem5: got %h want %h", dut.r_mem[5], ref_mem[5]); end
  endtask

  task automatic test_cs_boundary();
    int a0 = abort_cnt;
    cs_begin();
    cs_end();
    n_cmp++; if (abort_cnt != a0) begin n_fail++; $display("FAIL clean_cs_abort: got %0d want 0", abort_cnt - a0); end
  endtask

  task automatic test_simul_cs_edge();
    int d0 = done_cnt;
    int a0 = abort_cnt;
    logic [7:0] rx;
    cs_begin();
    spi_bits(8'hC7, 8, rx);
    spi_bits(8'hE1, 7, rx);
    mosi_i = 1'b1;
    half_bit();
    sclk_i = 1'b1;
    cs_n_i = 1'b1;
    half_bit();
    sclk_i = 1'b0;
    repeat (8) @(negedge pclk);
    n_cmp++; if (abort_cnt - a0 != 1) begin n_fail++; $display("FAIL simul_abort: got %0d want 1", abort_cnt - a0); end
    n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL simul_no_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (dut.r_mem[7] !== ref_mem[7]) begin n_fail++; $display("FAIL simul_mem7: got %h want %h", dut.r_mem[7], ref_mem[7]); end
  endtask

  task automatic test_read();
    int d0 = done_cnt;
    logic [7:0] rx, exp;
    exp = 8'hFF;
`ifdef SPI_SLV_READBACK_EN
    exp = ref_mem[3];
`endif
    cs_begin();
    send_frame(8'h03, 8'($urandom), rx);
    cs_end();
    n_cmp++; if (rx !== exp) begin n_fail++; $display("FAIL read_miso: got %h want %h", rx, exp); end
    n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL read_no_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (miso_o !== 1'b1) begin n_fail++; $display("FAIL read_miso_idle: got %b want 1", miso_o); end
    n_cmp++; if (dut.r_mem[3] !== ref_mem[3]) begin n_fail++; $display("FAIL read_mem3: got %h want %h", dut.r_mem[3], ref_mem[3]); end
  endtask

  task automatic test_mid_reset();
    int d0, a0;
    logic [7:0] rx;
    cs_begin();
    spi_bits(8'hD9, 8, rx);
    spi_bits(8'h55, 4, rx);
    prst_i = 1'b1;
    @(negedge pclk);
    clear_model();
    n_cmp++; if (miso_o !== 1'b1) begin n_fail++; $display("FAIL midrst_miso: got %b want 1", miso_o); end
    n_cmp++; if (wr_addr_o !== 4'h0) begin n_fail++; $display("FAIL midrst_wr_addr: got %h want 0", wr_addr_o); end
    n_cmp++; if (wr_data_o !== 8'h00) begin n_fail++; $display("FAIL midrst_wr_data: got %h want 00", wr_data_o); end
    n_cmp++; if (wr_done_o !== 1'b0 || abort_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_pulses: got done=%b abort=%b want 0 0", wr_done_o, abort_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (dut.r_mem[i] !== 8'h00) begin n_fail++; $display("FAIL midrst_mem[%0d]: got %h want 00", i, dut.r_mem[i]); end
    end
    prst_i = 1'b0;
    a0 = abort_cnt;
    repeat (4) @(negedge pclk);
    cs_n_i = 1'b1;
    repeat (8) @(negedge pclk);
    n_cmp++; if (abort_cnt != a0) begin n_fail++; $display("FAIL midrst_spurious_abort: got %0d want 0", abort_cnt - a0); end
    d0 = done_cnt;
    cs_begin();
    send_frame(8'h8C, 8'hA5, rx);
    cs_end();
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL midrst_next_done: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (dut.r_mem[12] !== 8'hA5) begin n_fail++; $display("FAIL midrst_next_mem12: got %h want a5", dut.r_mem[12]); end
  endtask

  task automatic test_addr_alias();
    logic [7:0] rx;
    cs_begin();
    send_frame(8'hF3, 8'h9A, rx);
    cs_end();
    n_cmp++; if (wr_addr_o !== 4'h3) begin n_fail++; $display("FAIL alias_addr: got %h want 3", wr_addr_o); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (dut.r_mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL alias_mem[%0d]: got %h want %h", i, dut.r_mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int d0 = done_cnt;
      int nwr = 0;
      int nfr = int'($urandom_range(1, 3));
      cs_begin();
      for (int f = 0; f < nfr; f++) begin
        logic [7:0] a, d, rx, exp;
        a = 8'($urandom);
        d = 8'($urandom);
        exp = 8'hFF;
`ifdef SPI_SLV_READBACK_EN
        if (!a[7]) exp = ref_mem[a[AW-1:0]];
`endif
        send_frame(a, d, rx);
        if (a[7]) nwr++;
        else begin
          n_cmp++;
          if (rx !== exp) begin n_fail++; $display("FAIL rand_read it%0d a=%h: got %h want %h", it, a, rx, exp); end
        end
      end
      cs_end();
      n_cmp++;
      if (done_cnt - d0 != nwr) begin n_fail++; $display("FAIL rand_done it%0d: got %0d want %0d", it, done_cnt - d0, nwr); end
    end
    n_cmp++; if (wr_addr_o !== last_addr) begin n_fail++; $display("FAIL rand_last_addr: got %h want %h", wr_addr_o, last_addr); end
    n_cmp++; if (wr_data_o !== last_data) begin n_fail++; $display("FAIL rand_last_data: got %h want %h", wr_data_o, last_data); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (dut.r_mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL rand_mem[%0d]: got %h want %h", i, dut.r_mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    prst_i = 1'b1;
    sclk_i = 1'b0;
    cs_n_i = 1'b1;
    mosi_i = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_abort();
    test_cs_boundary();
    test_simul_cs_edge();
    test_mid_reset();
    test_addr_alias();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
